// File: rtl/alu_mp_pkg.sv
// Shared definitions for the register-file sequencer: data width, instruction
// field positions, opcode constants and the sequencer state encoding.
package alu_mp_pkg;

    localparam int DATA_W = 32;

    localparam int OPC_W   = 6;
    localparam int REG_AW  = 5;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int SRC1_HI = 25;
    localparam int SRC1_LO = 21;
    localparam int SRC2_HI = 20;
    localparam int SRC2_LO = 16;
    localparam int DST_HI  = 15;
    localparam int DST_LO  = 11;

    typedef logic [OPC_W-1:0]  opcode_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam opcode_t OP_ADD = 6'd1;
    localparam opcode_t OP_SUB = 6'd2;
    localparam opcode_t OP_AND = 6'd3;
    localparam opcode_t OP_OR  = 6'd4;
    localparam opcode_t OP_XOR = 6'd5;
    localparam opcode_t OP_SLT = 6'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_ERR
    } state_t;

    function automatic logic op_legal(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer; illegal opcodes never reach it, so its
// default output is only a don't-care made concrete.
module rf_seq_alu #(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    import alu_mp_pkg::*;

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle register-file sequencer: IDLE -> READ -> EXEC -> WB per instruction.
// Define ALU_MP_ZERO_REG_EN to make register 0 read as zero and never be written.
module rf_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic              valid_opcode,
    output logic [4:0]        addr1,
    output logic [4:0]        addr2,
    output logic [4:0]        addr3,
    output logic [DATA_W-1:0] in,
    input  logic [DATA_W-1:0] out1,
    input  logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              err
);
    import alu_mp_pkg::*;

    state_t             state_q, state_d;
    opcode_t            op_q, op_d;
    reg_addr_t          dst_q, dst_d;
    reg_addr_t          addr1_q, addr1_d;
    reg_addr_t          addr2_q, addr2_d;
    reg_addr_t          addr3_q, addr3_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    logic [DATA_W-1:0]  in_q, in_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               instr_ready_q, instr_ready_d;
    logic               valid_opcode_q, valid_opcode_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    opcode_t            dec_op;
    reg_addr_t          dec_src1, dec_src2, dec_dst;
    logic [10:0]        instr_unused;
    logic [DATA_W-1:0]  rd_a, rd_b, alu_y;
    logic               wb_we;

    assign dec_op       = instr[OPC_HI:OPC_LO];
    assign dec_src1     = instr[SRC1_HI:SRC1_LO];
    assign dec_src2     = instr[SRC2_HI:SRC2_LO];
    assign dec_dst      = instr[DST_HI:DST_LO];
    assign instr_unused = instr[DST_LO-1:0];

`ifdef ALU_MP_ZERO_REG_EN
    // Register 0 is hard-wired: mask its read data and suppress its write.
    assign rd_a  = (addr1_q == '0) ? '0 : out1;
    assign rd_b  = (addr2_q == '0) ? '0 : out2;
    assign wb_we = (dst_q != '0);
`else
    assign rd_a  = out1;
    assign rd_b  = out2;
    assign wb_we = 1'b1;
`endif

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_q),
        .a  (op_a_q),
        .b  (op_b_q),
        .y  (alu_y)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        dst_d          = dst_q;
        addr1_d        = addr1_q;
        addr2_d        = addr2_q;
        addr3_d        = addr3_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        in_d           = in_q;
        result_d       = result_q;
        instr_ready_d  = 1'b0;
        valid_opcode_d = 1'b0;
        done_d         = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (op_legal(dec_op)) begin
                        state_d = ST_READ;
                        op_d    = dec_op;
                        dst_d   = dec_dst;
                        addr1_d = dec_src1;
                        addr2_d = dec_src2;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    instr_ready_d = 1'b1;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
                op_a_d  = rd_a;
                op_b_d  = rd_b;
            end
            // Write-back outputs are registered here so they appear exactly in WB.
            ST_EXEC: begin
                state_d        = ST_WB;
                result_d       = alu_y;
                in_d           = alu_y;
                addr3_d        = dst_q;
                valid_opcode_d = wb_we;
                done_d         = 1'b1;
            end
            ST_WB: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
            end
            ST_ERR: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
            end
            default: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            dst_q          <= '0;
            addr1_q        <= '0;
            addr2_q        <= '0;
            addr3_q        <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            in_q           <= '0;
            result_q       <= '0;
            instr_ready_q  <= 1'b1;
            valid_opcode_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            dst_q          <= dst_d;
            addr1_q        <= addr1_d;
            addr2_q        <= addr2_d;
            addr3_q        <= addr3_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            in_q           <= in_d;
            result_q       <= result_d;
            instr_ready_q  <= instr_ready_d;
            valid_opcode_q <= valid_opcode_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign instr_ready  = instr_ready_q;
    assign valid_opcode = valid_opcode_q;
    assign addr1        = addr1_q;
    assign addr2        = addr2_q;
    assign addr3        = addr3_q;
    assign in           = in_q;
    assign result       = result_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: directed cases plus random instructions against a
// register-file/ALU reference model. Honours ALU_MP_ZERO_REG_EN like the DUT.
module tb_rf_sequencer;

`ifdef ALU_MP_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        valid_opcode;
    logic [4:0]  addr1, addr2, addr3;
    logic [31:0] in;
    logic [31:0] out1, out2;
    logic [31:0] result;
    logic        done;
    logic        err;

    logic [31:0] rf  [32];
    logic [31:0] rfm [32];
    logic        tb_we;
    logic [4:0]  tb_wa;
    logic [31:0] tb_wd;

    logic [31:0] exp_res, exp_in;
    logic [4:0]  exp_a3;

    int checks = 0;
    int errors = 0;

    rf_sequencer #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .valid_opcode (valid_opcode),
        .addr1        (addr1),
        .addr2        (addr2),
        .addr3        (addr3),
        .in           (in),
        .out1         (out1),
        .out2         (out2),
        .result       (result),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign out1 = rf[addr1];
    assign out2 = rf[addr2];

    always @(posedge clk) begin
        if (valid_opcode) rf[addr3] <= in;
        else if (tb_we)   rf[tb_wa] <= tb_wd;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] d);
        logic [10:0] junk;
        junk = 11'($urandom);
        return {op, s1, s2, d, junk};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        return (ZERO_EN && a == 5'd0) ? 32'd0 : rfm[a];
    endfunction

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            6'd1: return a + b;
            6'd2: return a - b;
            6'd3: return a & b;
            6'd4: return a | b;
            6'd5: return a ^ b;
            6'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Starts and ends on a falling edge with the DUT idle.
    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        rfm[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Checks the four cycles following an acceptance edge and updates the model.
    task automatic track(input logic [5:0] op, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d);
        logic        legal, we;
        logic [31:0] y;
        legal = (op >= 6'd1 && op <= 6'd6);
        y     = ref_alu(op, rd_model(s1), rd_model(s2));
        we    = !(ZERO_EN && d == 5'd0);
        @(negedge clk);
        if (legal) begin
            chk("read_ready", 32'(instr_ready), 32'd0);
            chk("read_addr1", 32'(addr1), 32'(s1));
            chk("read_addr2", 32'(addr2), 32'(s2));
            chk("read_done", 32'(done), 32'd0);
            chk("read_we", 32'(valid_opcode), 32'd0);
            @(negedge clk);
            chk("exec_done", 32'(done), 32'd0);
            chk("exec_we", 32'(valid_opcode), 32'd0);
            chk("exec_addr3_hold", 32'(addr3), 32'(exp_a3));
            @(negedge clk);
            chk("wb_done", 32'(done), 32'd1);
            chk("wb_we", 32'(valid_opcode), 32'(we));
            chk("wb_addr3", 32'(addr3), 32'(d));
            chk("wb_in", in, y);
            chk("wb_result", result, y);
            if (we) rfm[d] = y;
            exp_res = y;
            exp_in  = y;
            exp_a3  = d;
            @(negedge clk);
            chk("post_ready", 32'(instr_ready), 32'd1);
            chk("post_done", 32'(done), 32'd0);
            chk("post_we", 32'(valid_opcode), 32'd0);
            chk("post_in_hold", in, exp_in);
            chk("post_result_hold", result, exp_res);
        end else begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_we", 32'(valid_opcode), 32'd0);
            chk("err_ready", 32'(instr_ready), 32'd0);
            chk("err_done", 32'(done), 32'd0);
            @(negedge clk);
            chk("err_clear", 32'(err), 32'd0);
            chk("err_ready_back", 32'(instr_ready), 32'd1);
            chk("err_we2", 32'(valid_opcode), 32'd0);
            chk("err_result_hold", result, exp_res);
            chk("err_in_hold", in, exp_in);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [4:0] d);
        instr_valid = 1'b1;
        instr       = mk(op, s1, s2, d);
        chk("accept_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        track(op, s1, s2, d);
    endtask

    // instr_valid stays high across both instructions.
    task automatic back_to_back(input logic [5:0] opa, input logic [4:0] s1a, input logic [4:0] s2a,
                                input logic [4:0] da, input logic [5:0] opb, input logic [4:0] s1b,
                                input logic [4:0] s2b, input logic [4:0] db);
        instr_valid = 1'b1;
        instr       = mk(opa, s1a, s2a, da);
        chk("b2b_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr = mk(opb, s1b, s2b, db);
        track(opa, s1a, s2a, da);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        track(opb, s1b, s2b, db);
    endtask

    task automatic reset_in_wb(input logic [5:0] op, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [4:0] d);
        instr_valid = 1'b1;
        instr       = mk(op, s1, s2, d);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rwb_in_wb", 32'(done), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rwb_we_async", 32'(valid_opcode), 32'd0);
        chk("rwb_done", 32'(done), 32'd0);
        chk("rwb_ready", 32'(instr_ready), 32'd1);
        chk("rwb_result", result, 32'd0);
        chk("rwb_in", in, 32'd0);
        exp_res = 32'd0;
        exp_in  = 32'd0;
        exp_a3  = 5'd0;
        @(negedge clk);
        chk("rwb_no_write", rf[d], rfm[d]);
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] op;
        logic [4:0] s1, s2, d;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        tb_we       = 1'b0;
        tb_wa       = 5'd0;
        tb_wd       = 32'd0;
        exp_res     = 32'd0;
        exp_in      = 32'd0;
        exp_a3      = 5'd0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_we", 32'(valid_opcode), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in", in, 32'd0);
        chk("rst_addr", {17'd0, addr1, addr2, addr3}, 32'd0);

        for (int i = 0; i < 32; i++) preload(5'(i), $urandom);
        preload(5'd5, 32'h12345678);
        preload(5'd10, 32'h00000008);
        preload(5'd1, 32'h00000000);
        preload(5'd2, 32'h00000001);
        preload(5'd6, 32'hA5A5A5A5);
        preload(5'd7, 32'h00000000);
        preload(5'd0, 32'hDEADBEEF);
        preload(5'd12, 32'h00000055);
        rst = 1'b0;

        run_instr(6'd1, 5'd5, 5'd10, 5'd3);
        chk("add_rf3", rf[3], 32'h12345680);
        run_instr(6'd2, 5'd1, 5'd2, 5'd4);
        chk("sub_wrap_rf4", rf[4], 32'hFFFFFFFF);
        run_instr(6'd6, 5'd6, 5'd7, 5'd8);
        chk("slt_rf8", rf[8], 32'h00000001);
        run_instr(6'h3F, 5'd5, 5'd10, 5'd9);
        chk("illegal_no_write", rf[9], rfm[9]);
        run_instr(6'd5, 5'd3, 5'd3, 5'd3);
        back_to_back(6'd1, 5'd5, 5'd10, 5'd13, 6'd2, 5'd13, 5'd10, 5'd14);
        run_instr(6'd1, 5'd0, 5'd10, 5'd0);
        reset_in_wb(6'd1, 5'd5, 5'd10, 5'd12);
        run_instr(6'd4, 5'd6, 5'd12, 5'd15);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) preload(5'($urandom), $urandom);
            case ($urandom_range(0, 9))
                0:       op = 6'($urandom);
                1:       op = 6'd0;
                2:       op = 6'd7;
                default: op = 6'($urandom_range(1, 6));
            endcase
            s1 = 5'($urandom);
            s2 = 5'($urandom);
            d  = 5'($urandom);
            if ($urandom_range(0, 4) == 0) back_to_back(op, s1, s2, d, 6'($urandom_range(1, 6)), d, s1, s2);
            else run_instr(op, s1, s2, d);
        end

        for (int i = 0; i < 32; i++) chk($sformatf("rf_final[%0d]", i), rf[i], rfm[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: instr_valid  in  1  instruction offered.
REQ-005 Port: instr  in  32  [31:26] opcode, [25:21] src1, [20:16] src2, [15:11] dst, [10:0] ignored.
REQ-006 Port: instr_ready  out  1  sequencer can accept an instruction.
REQ-007 Port: valid_opcode  out  1  register-file write enable.
REQ-008 Port: addr1, addr2, addr3  out  5 each  register-file read address 1, read address 2 and write address.
REQ-009 Port: in  out  32  register-file write data.
REQ-010 Port: out1, out2  in  32  register-file read data, combinational from addr1 and addr2.
REQ-011 Port: result  out  32  last computed value, held until the next write-back.
REQ-012 Port: done  out  1  one-cycle pulse on a completed write-back.
REQ-013 Port: err  out  1  one-cycle pulse on an illegal opcode.

Function
REQ-014 Opcodes: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT; all other values are illegal.
REQ-015 ADD and SUB wrap modulo 2^32, with no carry or overflow output.
REQ-016 SLT performs a signed compare and returns 1 or 0, zero-extended.
REQ-017 FSM states: IDLE, READ, EXEC, WB, ERR.
REQ-018 instr_ready is 1 only in IDLE.
REQ-019 Acceptance occurs when instr_valid and instr_ready are both 1 on a rising edge; instr is latched at that edge.
REQ-020 Transitions:
- IDLE->READ on acceptance of a legal opcode.
- IDLE->ERR on acceptance of an illegal opcode.
- READ->EXEC, EXEC->WB, WB->IDLE and ERR->IDLE each occur unconditionally on the next edge.
REQ-021 READ: addr1 = src1 and addr2 = src2; out1 and out2 are captured into operand registers at the READ->EXEC edge.
REQ-022 EXEC: the ALU result is registered at the EXEC->WB edge.
REQ-023 WB: valid_opcode = 1, addr3 = dst, in = result, done = 1, all for exactly one cycle.
REQ-024 Latency: with acceptance at edge N, done is high during the cycle after edge N+2; throughput is one instruction per 4 cycles.
REQ-025 ERR: err = 1 for one cycle; valid_opcode stays 0 and the register file is never written.
REQ-026 Outside WB: valid_opcode = 0, and in and addr3 hold their last values.
REQ-027 instr_valid is ignored outside IDLE, so no instruction is accepted or lost mid-operation.
REQ-028 If dst equals src1 or src2, the read uses the pre-write value; the write completes in WB.

Reset
REQ-029 On rst: state = IDLE, instr_ready = 1, and valid_opcode, done, err, addr1, addr2, addr3, in, result and the operand registers are all 0.
REQ-030 rst asserted in any state aborts the operation immediately; no write occurs, even when asserted during WB.
REQ-031 After rst is deasserted, the first acceptance is possible on the first rising edge.

Configuration
REQ-032 Macro ALU_MP_ZERO_REG_EN defined:
- Register 0 reads as 0 regardless of out1/out2.
- WB with dst = 0 drives valid_opcode = 0 but still pulses done.
REQ-033 Macro ALU_MP_ZERO_REG_EN undefined: register 0 is an ordinary register.

Structure
REQ-034 Shared package alu_mp_pkg holds:
- the opcode constants;
- the state enum;
- the field bit positions;
- DATA_W.
REQ-035 Combinational sub-module rf_seq_alu(op, a, b) -> y computes the result; the FSM and all registers stay in rf_sequencer.

Verification
REQ-036 Reset: rst pulse -> instr_ready = 1, valid_opcode = 0, result = 0.
REQ-037 ADD: out1 = 0x12345678, out2 = 0x00000008, instr ADD src1=5, src2=10, dst=3 -> WB drives addr3 = 3, in = 0x12345680, valid_opcode = 1, done = 1 three edges after acceptance.
REQ-038 SUB wrap and SLT:
- SUB with 0 - 1 -> in = 0xFFFFFFFF.
- SLT with 0xA5A5A5A5 vs 0 -> in = 1.
REQ-039 Illegal opcode 0x3F -> err pulse for one cycle, valid_opcode never 1, instr_ready back to 1 after 2 edges.
REQ-040 Back-to-back: instr_valid held high with two instructions -> second accepted exactly 4 edges after the first, first unaffected.
REQ-041 Reset during WB, and zero register:
- rst asserted in WB -> valid_opcode deasserts asynchronously, no done.
- With ALU_MP_ZERO_REG_EN, dst = 0 -> done = 1, valid_opcode = 0.
